sparc_ifu_thrsched: RTL and testbench

SPARC_IFU_THRSCHED -- requirements
Module: sparc_ifu_thrsched

---
 rtl/sparc_ifu_thrsched.sv | 124 ++++++++++++
 tb/tb_sparc_ifu_thrsched.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/sparc_ifu_thrsched.sv
// Four-thread IFU scheduler: picks the next ready thread by LRU order
// and rotates the running thread out once its quantum is used up.
module sparc_ifu_thrsched #(
  parameter int QUANTUM = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] thr_state_t0,
  input  logic [4:0] thr_state_t1,
  input  logic [4:0] thr_state_t2,
  input  logic [4:0] thr_state_t3,
  input  logic       hold,
  output logic [3:0] schedule,
  output logic [3:0] switch_out,
  output logic [3:0] cur_thr,
  output logic       thr_active
);

  localparam int QW = (QUANTUM > 1) ? $clog2(QUANTUM) : 1;
  localparam logic [QW-1:0] QMAX = QW'(QUANTUM - 1);

  typedef enum logic {S_IDLE, S_RUN} st_t;

  st_t             state, state_n;
  logic [1:0]      order   [4];
  logic [1:0]      order_n [4];
  logic [QW-1:0]   qcnt, qcnt_n;
  logic [3:0]      cur_n;
  logic [3:0]      rdy, run;
  logic [1:0]      pick, pick_pos;
  logic            pick_vld, c_run, sched_go;
  logic            unused_bits;

  // A code with both bit 4 and bit 2 set is a ready code, not a run code.
  assign rdy = {thr_state_t3[4], thr_state_t2[4],
                thr_state_t1[4], thr_state_t0[4]};
  assign run = {thr_state_t3[2] & ~thr_state_t3[4],
                thr_state_t2[2] & ~thr_state_t2[4],
                thr_state_t1[2] & ~thr_state_t1[4],
                thr_state_t0[2] & ~thr_state_t0[4]};

  assign unused_bits = ^{thr_state_t0[3], thr_state_t0[1:0],
                         thr_state_t1[3], thr_state_t1[1:0],
                         thr_state_t2[3], thr_state_t2[1:0],
                         thr_state_t3[3], thr_state_t3[1:0]};

  assign pick_vld = |rdy;
  assign c_run    = |(cur_thr & run);
  assign sched_go = |schedule;

  always_comb begin
    pick     = '0;
    pick_pos = '0;
    for (int i = 3; i >= 0; i--) begin
      if (rdy[order[i]]) begin
        pick     = order[i];
        pick_pos = 2'(i);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      cur_thr    <= '0;
      thr_active <= 1'b0;
      qcnt       <= '0;
      order[0]   <= 2'd0;
      order[1]   <= 2'd1;
      order[2]   <= 2'd2;
      order[3]   <= 2'd3;
    end else begin
      state      <= state_n;
      cur_thr    <= cur_n;
      thr_active <= |cur_n;
      qcnt       <= qcnt_n;
      order      <= order_n;
    end
  end

  always_comb begin
    state_n = state;
    cur_n   = cur_thr;
    qcnt_n  = qcnt;
    order_n = order;
    unique case (state)
      S_IDLE: if (sched_go) state_n = S_RUN;
      S_RUN:  if (!c_run && !sched_go) state_n = S_IDLE;
    endcase
    if (sched_go) begin
      cur_n  = schedule;
      qcnt_n = '0;
      for (int i = 0; i < 3; i++) begin
        if (2'(i) >= pick_pos) order_n[i] = order[i+1];
      end
      order_n[3] = pick;
    end else if (state_n == S_IDLE) begin
      cur_n  = '0;
      qcnt_n = '0;
    end else if (!hold && qcnt != QMAX) begin
      qcnt_n = qcnt + 1'b1;
    end
  end

  // Pulses are gated by reset so nothing leaks out while it is asserted.
  always_comb begin
    schedule   = '0;
    switch_out = '0;
    if (!reset && !hold && pick_vld) begin
      unique case (state)
        S_IDLE: schedule = 4'b0001 << pick;
        S_RUN: begin
          if (!c_run) begin
            schedule = 4'b0001 << pick;
          end else if (qcnt == QMAX) begin
            schedule   = 4'b0001 << pick;
            switch_out = cur_thr;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sparc_ifu_thrsched.sv
// Vector/scoreboard bench for sparc_ifu_thrsched with QUANTUM=4.
// Expected values are hand-derived cycle by cycle.
module tb_sparc_ifu_thrsched;

  localparam logic [4:0] I  = 5'b00000;
  localparam logic [4:0] R  = 5'b11001;
  localparam logic [4:0] U  = 5'b00101;
  localparam logic [4:0] W  = 5'b00001;
  localparam logic [4:0] SR = 5'b10011;
  localparam logic [4:0] SU = 5'b00111;
  localparam logic [4:0] RX = 5'b10101;

  typedef struct {
    logic [4:0] t0, t1, t2, t3;
    logic       hold, rst;
    logic [3:0] sched, sw, cur;
    logic       act;
  } vec_t;

  typedef struct {
    logic [3:0] sched, sw, cur;
    logic       act;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] t0 = I, t1 = I, t2 = I, t3 = I;
  logic       hold = 1'b0;
  logic [3:0] schedule, switch_out, cur_thr;
  logic       thr_active;

  int checks = 0;
  int failures = 0;

  vec_t vq[$];
  exp_t sbq[$];

  sparc_ifu_thrsched #(.QUANTUM(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .thr_state_t0 (t0),
    .thr_state_t1 (t1),
    .thr_state_t2 (t2),
    .thr_state_t3 (t3),
    .hold         (hold),
    .schedule     (schedule),
    .switch_out   (switch_out),
    .cur_thr      (cur_thr),
    .thr_active   (thr_active)
  );

  always #5 clk = ~clk;

  task automatic add(input logic [4:0] a0, a1, a2, a3,
                     input logic h, r,
                     input logic [3:0] s, w, c,
                     input logic ac);
    vq.push_back('{a0, a1, a2, a3, h, r, s, w, c, ac});
  endtask

  task automatic chk(input string nm, input int idx,
                     input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s vec=%0d got=%b exp=%b", nm, idx, got, exp);
    end
  endtask

  initial begin
    exp_t e;
    int   lat;
    // t0 t1 t2 t3 hold rst | sched sw cur act
    add(I, R, I, R, 0, 1, 4'b0000, 4'b0000, 4'b0000, 0);
    add(I, R, I, R, 0, 0, 4'b0010, 4'b0000, 4'b0000, 0);
    add(I, U, I, R, 0, 0, 4'b0000, 4'b0000, 4'b0010, 1);
    add(I, U, I, R, 0, 0, 4'b0000, 4'b0000, 4'b0010, 1);
    for (int k = 0; k < 5; k++)
      add(R, U, I, R, 1, 0, 4'b0000, 4'b0000, 4'b0010, 1);
    add(R, U, I, R, 0, 0, 4'b0000, 4'b0000, 4'b0010, 1);
    add(R, U, I, R, 0, 0, 4'b0001, 4'b0010, 4'b0010, 1);
    add(U, R, I, R, 0, 0, 4'b0000, 4'b0000, 4'b0001, 1);
    add(W, I, I, I, 0, 0, 4'b0000, 4'b0000, 4'b0001, 1);
    add(I, I, I, I, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0);
    add(I, I, R, I, 0, 0, 4'b0100, 4'b0000, 4'b0000, 0);
    for (int k = 0; k < 10; k++)
      add(I, I, U, I, 0, 0, 4'b0000, 4'b0000, 4'b0100, 1);
    add(I, I, U, R, 0, 0, 4'b1000, 4'b0100, 4'b0100, 1);
    add(I, I, R, U, 0, 0, 4'b0000, 4'b0000, 4'b1000, 1);
    add(I, I, R, U, 0, 1, 4'b0000, 4'b0000, 4'b0000, 0);
    add(R, R, I, I, 0, 0, 4'b0001, 4'b0000, 4'b0000, 0);
    add(SU, I, I, SR, 0, 0, 4'b0000, 4'b0000, 4'b0001, 1);
    add(RX, I, I, SR, 0, 0, 4'b1000, 4'b0000, 4'b0001, 1);
    add(I, I, I, U, 0, 0, 4'b0000, 4'b0000, 4'b1000, 1);
    add(I, R, I, W, 1, 0, 4'b0000, 4'b0000, 4'b1000, 1);
    add(I, R, I, I, 1, 0, 4'b0000, 4'b0000, 4'b0000, 0);
    add(I, R, I, I, 0, 0, 4'b0010, 4'b0000, 4'b0000, 0);
    add(I, U, I, I, 0, 0, 4'b0000, 4'b0000, 4'b0010, 1);

    foreach (vq[i]) begin
      @(negedge clk);
      t0 = vq[i].t0; t1 = vq[i].t1;
      t2 = vq[i].t2; t3 = vq[i].t3;
      hold = vq[i].hold; reset = vq[i].rst;
      sbq.push_back('{vq[i].sched, vq[i].sw, vq[i].cur, vq[i].act});
      #2;
      e = sbq.pop_front();
      chk("schedule", i, schedule, e.sched);
      chk("switch_out", i, switch_out, e.sw);
      chk("cur_thr", i, cur_thr, e.cur);
      chk("thr_active", i, {3'b000, thr_active}, {3'b000, e.act});
    end

    // T1 has used one quantum cycle; T2 waits. Switch expected at qcnt=3.
    lat = -1;
    for (int k = 0; k < 10 && lat < 0; k++) begin
      @(negedge clk);
      t0 = I; t1 = U; t2 = R; t3 = I; hold = 1'b0;
      #2;
      if (switch_out != 4'b0000) begin
        lat = k;
        chk("q_switch_out", k, switch_out, 4'b0010);
        chk("q_schedule", k, schedule, 4'b0100);
      end
    end
    checks++;
    if (lat != 2) begin
      failures++;
      $display("FAIL q_latency got=%0d exp=2", lat);
    end
    @(negedge clk);
    t1 = R; t2 = U;
    #2;
    chk("q_cur_thr", 0, cur_thr, 4'b0100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
